// File: rtl/conv3x3_filter_if.sv
// Window/pixel bus between the 3x3 window reader, the filter and the write-side memory.
// The source drives a 9-pixel window with in_valid; the filter returns pixel_out with out_valid.
interface conv3x3_filter_if;
    logic       in_valid;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic [7:0] pixel_out;
    logic       out_valid;

    modport master (
        output in_valid, p1, p2, p3, p4, p5, p6, p7, p8, p9,
        input  pixel_out, out_valid
    );

    modport slave (
        input  in_valid, p1, p2, p3, p4, p5, p6, p7, p8, p9,
        output pixel_out, out_valid
    );
endinterface

// File: rtl/conv3x3_filter.sv
// 3x3 kernel filter (pass / Gaussian / Sobel / sharpen) with a 3-stage pipeline,
// frame sequencing and an end-of-frame done pulse.
module conv3x3_filter #(
    parameter int FRAME_PIX = 8192,
    parameter int CNT_W     = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    conv3x3_filter_if.slave      win,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     pix_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIX - 1);

    state_t           state_q, state_d;
    logic             frame_start;
    logic             accept;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] pix_q;
    logic [3:1]       vld_q;

    // Stage 1 partial sums
    logic [9:0]  row_t_d, row_m_d, row_b_d, col_l_d, col_r_d, cross_d;
    logic [10:0] c5_d;
    logic [9:0]  row_t_q, row_m_q, row_b_q, col_l_q, col_r_q, cross_q;
    logic [10:0] c5_q;
    logic [7:0]  ctr_q;

    // Stage 2 final sums
    logic [11:0]        gauss_sum;
    logic signed [10:0] gx, gy;
    logic [9:0]         gx_abs, gy_abs;
    logic [11:0]        sobel_mag;
    logic signed [12:0] sharp_t;
    logic signed [12:0] s2_val_d, s2_val_q;

    // Stage 3 scale/clamp
    logic signed [12:0] scaled;
    logic [7:0]         pixel_d, pixel_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        accept      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    frame_start = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (win.in_valid) begin
                    accept = 1'b1;
                    if (acc_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leaves on the cycle the last pixel sits in the output register.
                if (!vld_q[1] && !vld_q[2]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            pix_q  <= '0;
            mode_q <= 2'd0;
        end else if (frame_start) begin
            acc_q  <= '0;
            pix_q  <= '0;
            mode_q <= mode_i;
        end else begin
            if (accept) begin
                acc_q <= acc_q + 1'b1;
            end
            if (vld_q[3]) begin
                pix_q <= pix_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[2:1], accept};
        end
    end

    always_comb begin
        row_t_d = {2'b0, win.p1} + {1'b0, win.p2, 1'b0} + {2'b0, win.p3};
        row_m_d = {2'b0, win.p4} + {1'b0, win.p5, 1'b0} + {2'b0, win.p6};
        row_b_d = {2'b0, win.p7} + {1'b0, win.p8, 1'b0} + {2'b0, win.p9};
        col_l_d = {2'b0, win.p1} + {1'b0, win.p4, 1'b0} + {2'b0, win.p7};
        col_r_d = {2'b0, win.p3} + {1'b0, win.p6, 1'b0} + {2'b0, win.p9};
        cross_d = {2'b0, win.p2} + {2'b0, win.p4} + {2'b0, win.p6} + {2'b0, win.p8};
        c5_d    = {3'b0, win.p5} + {1'b0, win.p5, 2'b0};
    end

    always_ff @(posedge clk) begin
        row_t_q <= row_t_d;
        row_m_q <= row_m_d;
        row_b_q <= row_b_d;
        col_l_q <= col_l_d;
        col_r_q <= col_r_d;
        cross_q <= cross_d;
        c5_q    <= c5_d;
        ctr_q   <= win.p5;
    end

    always_comb begin
        gauss_sum = {2'b0, row_t_q} + {1'b0, row_m_q, 1'b0} + {2'b0, row_b_q};
        gx        = $signed({1'b0, col_r_q}) - $signed({1'b0, col_l_q});
        gy        = $signed({1'b0, row_b_q}) - $signed({1'b0, row_t_q});
        gx_abs    = gx[10] ? 10'(-gx) : 10'(gx);
        gy_abs    = gy[10] ? 10'(-gy) : 10'(gy);
        sobel_mag = {2'b0, gx_abs} + {2'b0, gy_abs};
        sharp_t   = $signed({2'b0, c5_q}) - $signed({3'b0, cross_q});
        case (mode_q)
            2'd0:    s2_val_d = {5'b0, ctr_q};
            2'd1:    s2_val_d = {1'b0, gauss_sum};
            2'd2:    s2_val_d = {1'b0, sobel_mag};
            default: s2_val_d = sharp_t;
        endcase
    end

    always_ff @(posedge clk) begin
        s2_val_q <= s2_val_d;
    end

    always_comb begin
        scaled  = (mode_q == 2'd1) ? (s2_val_q >>> 4) : s2_val_q;
        pixel_d = 8'd0;
        if (vld_q[2]) begin
            if (scaled[12]) begin
                pixel_d = 8'd0;
            end else if (scaled > 13'sd255) begin
                pixel_d = 8'hFF;
            end else begin
                pixel_d = scaled[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_q <= 8'd0;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign win.pixel_out = pixel_q;
    assign win.out_valid = vld_q[3];
    assign busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o        = (state_q == S_DONE);
    assign pix_count_o   = pix_q;

endmodule

// File: tb/tb_conv3x3_filter.sv
// Directed bench for conv3x3_filter: windows are scored against a reference model
// through a queue and popped as pixels leave the pipe.
module tb_conv3x3_filter;

    localparam int FP = 4;
    localparam int CW = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          busy;
    logic          done;
    logic [CW-1:0] pix_count;

    conv3x3_filter_if bus();

    conv3x3_filter #(.FRAME_PIX(FP), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .mode_i      (mode),
        .win         (bus),
        .busy_o      (busy),
        .done_o      (done),
        .pix_count_o (pix_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int pix;
        int at;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   last_out = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int model(input int m, input int w[9]);
        int gx, gy, s, r;
        case (m)
            0: r = w[4];
            1: r = (w[0] + 2*w[1] + w[2] + 2*w[3] + 4*w[4] + 2*w[5] + w[6] + 2*w[7] + w[8]) / 16;
            2: begin
                gx = (w[2] + 2*w[5] + w[8]) - (w[0] + 2*w[3] + w[6]);
                gy = (w[6] + 2*w[7] + w[8]) - (w[0] + 2*w[1] + w[2]);
                s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                r  = (s > 255) ? 255 : s;
            end
            default: begin
                s = 5*w[4] - (w[1] + w[3] + w[5] + w[7]);
                r = (s < 0) ? 0 : ((s > 255) ? 255 : s);
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("out_valid_unexpected", 32'(bus.out_valid), 0);
                end else begin
                    mon_e = sbq.pop_front();
                    $display("out cyc=%0d pixel=%0d expected=%0d", cyc, bus.pixel_out, mon_e.pix);
                    chk("pixel", 32'(bus.pixel_out), mon_e.pix);
                    chk("latency", cyc, mon_e.at);
                    last_out = cyc;
                end
            end else begin
                chk("pixel_zero_gap", 32'(bus.pixel_out), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input int w[9]);
        bus.p1 = 8'(w[0]); bus.p2 = 8'(w[1]); bus.p3 = 8'(w[2]);
        bus.p4 = 8'(w[3]); bus.p5 = 8'(w[4]); bus.p6 = 8'(w[5]);
        bus.p7 = 8'(w[6]); bus.p8 = 8'(w[7]); bus.p9 = 8'(w[8]);
    endtask

    task automatic rnd_win(output int w[9]);
        for (int i = 0; i < 9; i++) w[i] = $urandom_range(0, 255);
    endtask

    task automatic send(input int m, input int w[9]);
        exp_t e;
        set_win(w);
        bus.in_valid = 1'b1;
        e.pix = model(m, w);
        e.at  = cyc + 3;
        sbq.push_back(e);
        $display("in  cyc=%0d mode=%0d p5=%0d expected=%0d due=%0d", cyc, m, w[4], e.pix, e.at);
        tick();
    endtask

    task automatic gap();
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic begin_frame(input int m);
        bus.in_valid = 1'b0;
        mode  = 2'(m);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_run", 32'(busy), 1);
    endtask

    task automatic finish_frame();
        int n = 0;
        bus.in_valid = 1'b0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 1);
        chk("done_after_last_out", cyc, last_out + 1);
        chk("pix_count_final", 32'(pix_count), FP);
        chk("busy_at_done", 32'(busy), 0);
        chk("sb_empty", sbq.size(), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 0);
        chk("start_on_done_ignored", 32'(busy), 0);
        chk("pix_count_hold", 32'(pix_count), FP);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w[9];
        int done_cnt;

        bus.in_valid = 1'b0;
        set_win('{0, 0, 0, 0, 0, 0, 0, 0, 0});
        rst_n = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pix_count", 32'(pix_count), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_pixel_out", 32'(bus.pixel_out), 0);
        rst_n = 1'b1;
        tick();

        // in_valid while idle must be ignored
        for (int i = 0; i < 3; i++) begin
            rnd_win(w);
            set_win(w);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("idle_pix_count", 32'(pix_count), 0);
        chk("idle_busy", 32'(busy), 0);

        // Gaussian, flat field, back to back
        begin_frame(1);
        w = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
        for (int i = 0; i < FP; i++) send(1, w);
        finish_frame();

        // Sobel
        begin_frame(2);
        w = '{0, 128, 255, 0, 128, 255, 0, 128, 255};
        send(2, w);
        w = '{77, 77, 77, 77, 77, 77, 77, 77, 77};
        send(2, w);
        rnd_win(w);
        send(2, w);
        rnd_win(w);
        send(2, w);
        finish_frame();

        // Sharpen with clamps at both ends
        begin_frame(3);
        w = '{255, 255, 255, 255, 0, 255, 255, 255, 255};
        send(3, w);
        w = '{0, 0, 0, 0, 255, 0, 0, 0, 0};
        send(3, w);
        w = '{9, 50, 9, 50, 60, 50, 9, 50, 9};
        send(3, w);
        rnd_win(w);
        send(3, w);
        finish_frame();

        // Gaps in in_valid: 1,0,1,1,0,1
        begin_frame(1);
        rnd_win(w); send(1, w);
        gap();
        rnd_win(w); send(1, w);
        rnd_win(w); send(1, w);
        gap();
        rnd_win(w); send(1, w);
        finish_frame();

        // Mode change and extra start mid-frame use the latched mode
        begin_frame(3);
        rnd_win(w); send(3, w);
        rnd_win(w); send(3, w);
        mode  = 2'd1;
        start = 1'b1;
        rnd_win(w); send(3, w);
        start = 1'b0;
        rnd_win(w); send(3, w);
        finish_frame();

        // Reset in idle clears the held pixel count
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_idle_pix_count", 32'(pix_count), 0);

        // Abort a frame with reset after two windows
        begin_frame(2);
        rnd_win(w); send(2, w);
        rnd_win(w); send(2, w);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        sbq.delete();
        tick();
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_pix_count", 32'(pix_count), 0);
        chk("abort_busy", 32'(busy), 0);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);

        // Full pass-through frame after the abort
        begin_frame(0);
        for (int i = 0; i < FP; i++) begin
            rnd_win(w);
            send(0, w);
        end
        finish_frame();

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
